// File: rtl/multi_channel_energy_logger.sv
// Multi-channel energy logger: gain-converts samples, averages per-channel windows
// (or bypasses), and queues {ch, avg, peak} records in a small output FIFO.
module mcel_chan #(
  parameter int WIDTH    = 8,
  parameter int WIN_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_zero,
  input  logic             i_hit,
  input  logic [WIDTH-1:0] i_conv,
  output logic             o_done,
  output logic [WIDTH-1:0] o_avg,
  output logic [WIDTH-1:0] o_peak
);
  localparam int SW = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FULL = {1'b1, {WIN_LOG2{1'b0}}};

  logic [SW-1:0]     r_sum, w_sum_b, w_sum_n;
  logic [WIDTH-1:0]  r_peak, w_peak_b, w_peak_n;
  logic [WIN_LOG2:0] r_cnt, w_cnt_b, w_cnt_n;

  // A zero request at the same edge as a sample clears first, then accumulates.
  assign w_sum_b  = i_zero ? '0 : r_sum;
  assign w_peak_b = i_zero ? '0 : r_peak;
  assign w_cnt_b  = i_zero ? '0 : r_cnt;
  assign w_sum_n  = w_sum_b + SW'(i_conv);
  assign w_peak_n = (i_conv > w_peak_b) ? i_conv : w_peak_b;
  assign w_cnt_n  = w_cnt_b + (WIN_LOG2+1)'(1);
  assign o_done   = i_hit && (w_cnt_n == FULL);
  assign o_avg    = w_sum_n[SW-1:WIN_LOG2];
  assign o_peak   = w_peak_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0; r_peak <= '0; r_cnt <= '0;
    end else if (i_hit && !o_done) begin
      r_sum <= w_sum_n; r_peak <= w_peak_n; r_cnt <= w_cnt_n;
    end else if (i_hit || i_zero) begin
      r_sum <= '0; r_peak <= '0; r_cnt <= '0;
    end
  end
endmodule

module multi_channel_energy_logger #(
  parameter  int WIDTH      = 8,
  parameter  int CHANNELS   = 4,
  parameter  int WIN_LOG2   = 3,
  parameter  int GAIN_Q2    = 5,
  parameter  int FIFO_DEPTH = 4,
  localparam int CHB        = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CHB-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHB-1:0]   out_ch,
  output logic [WIDTH-1:0] out_avg,
  output logic [WIDTH-1:0] out_peak,
  output logic             overflow
);
  localparam int PW = WIDTH + 8;
  localparam int FB = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CHB-1:0]   ch;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] peak;
  } rec_t;

  logic [PW-1:0]    w_prod, w_shr;
  logic [WIDTH-1:0] w_conv;
  logic             w_ch_ok;
  logic             r_s1_vld, r_prev_mode;
  logic [CHB-1:0]   r_s1_ch;
  logic [WIDTH-1:0] r_s1_conv;

  assign w_prod  = PW'(in_data) * PW'(GAIN_Q2);
  assign w_shr   = w_prod >> 2;
  assign w_conv  = (|w_shr[PW-1:WIDTH]) ? '1 : w_shr[WIDTH-1:0];
  assign w_ch_ok = ({1'b0, in_ch} < (CHB+1)'(CHANNELS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0; r_s1_ch <= '0; r_s1_conv <= '0; r_prev_mode <= 1'b0;
    end else begin
      r_prev_mode <= mode;
      r_s1_vld    <= in_valid && w_ch_ok && !clr;
      if (in_valid && !clr) begin
        r_s1_ch   <= in_ch;
        r_s1_conv <= w_conv;
      end
    end
  end

  logic                              w_zero;
  logic [CHANNELS-1:0]               w_hit, w_done;
  logic [CHANNELS-1:0][WIDTH-1:0]    w_avg, w_peak;

  assign w_zero = clr || (mode != r_prev_mode);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_hit[g] = r_s1_vld && !clr && !mode && (r_s1_ch == CHB'(g));
    mcel_chan #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) u_ch (
      .clk(clk), .rst_n(rst_n), .i_zero(w_zero), .i_hit(w_hit[g]), .i_conv(r_s1_conv),
      .o_done(w_done[g]), .o_avg(w_avg[g]), .o_peak(w_peak[g])
    );
  end

  rec_t w_rec;
  logic w_push;

  always_comb begin
    w_rec = '{ch: r_s1_ch, avg: r_s1_conv, peak: r_s1_conv};
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_s1_ch == CHB'(i)) begin
          w_rec.avg  = w_avg[i];
          w_rec.peak = w_peak[i];
        end
      end
    end
  end

  assign w_push = r_s1_vld && !clr && (mode || (|w_done));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [FB:0] r_wp, r_rp;
  logic        w_empty, w_full, w_pop, w_wr, r_ovf;
  rec_t        r_mem [FIFO_DEPTH];
  rec_t        w_head;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[FB] != r_rp[FB]) && (r_wp[FB-1:0] == r_rp[FB-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0; r_rp <= '0; r_ovf <= 1'b0;
    end else if (clr) begin
      r_wp <= '0; r_rp <= '0; r_ovf <= 1'b0;
    end else begin
      if (w_wr)                      r_wp  <= r_wp + (FB+1)'(1);
      if (w_pop)                     r_rp  <= r_rp + (FB+1)'(1);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[FB-1:0]] <= w_rec;
  end

  // Storage is not reset; outputs are masked so reset and clear read as zero.
  assign w_head    = r_mem[r_rp[FB-1:0]];
  assign out_valid = !w_empty;
  assign out_ch    = out_valid ? w_head.ch   : '0;
  assign out_avg   = out_valid ? w_head.avg  : '0;
  assign out_peak  = out_valid ? w_head.peak : '0;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_multi_channel_energy_logger.sv
// Directed bench for multi_channel_energy_logger (CHANNELS=5 so that
// out-of-range channel codes are expressible).
module tb_multi_channel_energy_logger;
  localparam int WIDTH = 8, CHANNELS = 5, CHB = 3;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, mode, clr, out_ready;
  logic [CHB-1:0]   in_ch;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, overflow;
  logic [CHB-1:0]   out_ch;
  logic [WIDTH-1:0] out_avg, out_peak;

  int checks = 0, failures = 0;

  multi_channel_energy_logger #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .WIN_LOG2(3),
                                .GAIN_Q2(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .mode(mode), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_avg(out_avg), .out_peak(out_peak), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int ch, input int data);
    in_valid = 1'b1;
    in_ch    = CHB'(ch);
    in_data  = WIDTH'(data);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int v, input int ch, input int avg, input int pk);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_ch"},    32'(out_ch),    32'(ch));
    chk({tag, "_avg"},   32'(out_avg),   32'(avg));
    chk({tag, "_peak"},  32'(out_peak),  32'(pk));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk_rec("reset", 0, 0, 0, 0);
    chk("reset_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // ch1 window of 100s: conv 125
    for (int i = 0; i < 7; i++) sample(1, 100);
    chk("avg1_early7", 32'(out_valid), 0);
    sample(1, 100);
    chk("avg1_early8", 32'(out_valid), 0);
    tick();
    chk_rec("avg1", 1, 1, 125, 125);
    tick();
    chk("avg1_popped", 32'(out_valid), 0);

    // ch0 ramp 8..64: conv 10..80, sum 360 -> 45, peak 80; held while not ready
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) sample(0, 8 * k);
    tick();
    chk_rec("ramp", 1, 0, 45, 80);
    tick();
    chk_rec("ramp_hold", 1, 0, 45, 80);
    out_ready = 1'b1;
    tick();
    chk("ramp_popped", 32'(out_valid), 0);

    // interleaved partial windows, then mode toggle clears them
    sample(0, 4); sample(3, 4); sample(0, 4); sample(3, 4);
    tick();
    mode = 1'b1;
    sample(3, 8);
    tick();
    chk_rec("toggle_bypass", 1, 3, 10, 10);
    mode = 1'b0;
    tick();
    chk("toggle_popped", 32'(out_valid), 0);
    for (int i = 0; i < 6; i++) sample(0, 40);
    tick(); tick();
    chk("toggle_no_stale", 32'(out_valid), 0);
    sample(0, 40); sample(0, 40);
    tick();
    chk_rec("toggle_fresh", 1, 0, 50, 50);
    tick();

    // bypass overflow: conv of 1..6 = 1,2,3,5,6,7; only four fit
    mode = 1'b1; out_ready = 1'b0;
    tick();
    for (int v = 1; v <= 6; v++) sample(2, v);
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk_rec("ovf_head", 1, 2, 1, 1);
    tick();
    chk_rec("ovf_hold", 1, 2, 1, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // refill to full, then push and pop at the same edge; 255 saturates
    sample(2, 4); sample(2, 8); sample(2, 12); sample(2, 16);
    tick();
    chk("full_ovf0", 32'(overflow), 0);
    chk_rec("full_head", 1, 2, 5, 5);
    sample(4, 255);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_ovf", 32'(overflow), 0);
    chk_rec("pushpop_head", 1, 2, 10, 10);
    out_ready = 1'b1;
    tick();
    chk_rec("drain15", 1, 2, 15, 15);
    tick();
    chk_rec("drain20", 1, 2, 20, 20);
    tick();
    chk_rec("drain_sat", 1, 4, 255, 255);
    tick();
    chk("drain_empty", 32'(out_valid), 0);

    // out-of-range channels have no effect
    sample(5, 100); sample(7, 100);
    tick(); tick();
    chk("badch_valid", 32'(out_valid), 0);
    chk("badch_ovf", 32'(overflow), 0);

    // reset mid-window with a buffered record
    mode = 1'b0; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) sample(1, 100);
    tick();
    chk_rec("pre_rst", 1, 1, 125, 125);
    rst_n = 1'b0;
    #1;
    chk_rec("async_rst", 0, 0, 0, 0);
    chk("async_rst_ovf", 32'(overflow), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) sample(1, 100);
    tick(); tick();
    chk("post_rst_partial", 32'(out_valid), 0);
    sample(1, 100);
    tick();
    chk_rec("post_rst_full", 1, 1, 125, 125);
    out_ready = 1'b1;
    tick();
    chk("post_rst_popped", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_channel_energy_logger.md
MULTI_CHANNEL_ENERGY_LOGGER -- requirements
Module: multi_channel_energy_logger

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample and result bit width.
REQ-002 SHALL have parameter CHANNELS, default 4, number of source channels (>=2); CHB = clog2(CHANNELS).
REQ-003 SHALL have parameter WIN_LOG2, default 3, averaging window of 2^WIN_LOG2 samples per channel.
REQ-004 SHALL have parameter GAIN_Q2, default 5, converter gain in quarter units (5 = x1.25).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output record buffer depth (power of two).
REQ-006 SHALL have ports, in order: clk in 1, system clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have in_valid in 1, sample strobe; in_ch in CHB, sample channel; in_data in WIDTH, raw input voltage code.
REQ-008 SHALL have mode in 1: 0 = window-average, 1 = bypass; clr in 1, synchronous clear.
REQ-009 SHALL have out_valid out 1; out_ready in 1; out_ch out CHB; out_avg out WIDTH; out_peak out WIDTH.
REQ-010 SHALL have overflow out 1, sticky record-drop flag.

Function
REQ-011 SHALL convert each sample: conv = min((in_data * GAIN_Q2) >> 2, 2^WIDTH-1), product held at WIDTH+8 bits, truncating shift, no wrap.
REQ-012 SHALL register conv, in_ch and valid at the edge sampling in_valid=1 (stage 1).
REQ-013 SHALL ignore samples with in_ch >= CHANNELS (no accumulator, FIFO or flag change).
REQ-014 SHALL keep per channel: sum (WIDTH+WIN_LOG2 bits), peak (WIDTH), count (WIN_LOG2+1 bits), all updated at stage 2 (edge after stage 1).
REQ-015 Average mode: SHALL add conv to sum, set peak = max(peak, conv), increment count.
REQ-016 Average mode: when the incoming sample makes count = 2^WIN_LOG2, SHALL push {ch, sum_total >> WIN_LOG2, peak_total} (totals including that sample) and zero that channel's sum, peak and count at the same edge.
REQ-017 Bypass mode: SHALL push {ch, conv, conv} for every valid stage-1 sample; accumulators untouched.
REQ-018 SHALL zero all accumulators of all channels at the edge where mode differs from its value at the previous edge; a stage-2 sample at that edge is processed in the new mode after clearing.
REQ-019 Record SHALL appear on outputs the cycle after the push edge, i.e. 2 edges after the sampling edge of the completing sample.
REQ-020 out_valid SHALL equal FIFO non-empty; head record drives out_ch/out_avg/out_peak; pop on out_valid & out_ready.
REQ-021 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Push with FIFO full and no pop SHALL drop the new record and set overflow; push and pop at the same edge while full SHALL both succeed.
REQ-023 Push and pop at the same edge while empty: record SHALL be stored and out_valid set next cycle (no fall-through).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; records SHALL leave in push order.
REQ-025 clr=1 SHALL at the next edge empty the FIFO, zero accumulators, clear overflow and discard stage 1; clr dominates in_valid and pop.

Reset
REQ-026 rst_n=0 SHALL immediately force out_valid=0, overflow=0, out_ch/out_avg/out_peak=0, FIFO empty, all accumulators and stage 1 zero, previous-mode register=0.
REQ-027 Reset mid-window or mid-handshake SHALL discard all partial sums and buffered records; first post-reset record requires a full new window.

Verification
REQ-028 Average mode, ch1, eight samples in_data=100, out_ready=1 -> one record ch=1, avg=125, peak=125, out_valid 2 cycles after 8th sampling edge.
REQ-029 Average mode, ch0, samples 8,16,...,64 -> record ch=0, avg=45, peak=80; in_data=255 -> conv saturates to 255.
REQ-030 Bypass, out_ready=0, six samples ch2 values 1..6 -> four records (conv 1,2,3,5) held in order, overflow=1; clr -> out_valid=0, overflow=0.
REQ-031 Average mode, interleaved ch0/ch3 samples, 4 then mode toggles to 1 and back -> no average record from pre-toggle samples; bypass records only while mode=1.
REQ-032 FIFO full, out_ready=1 with simultaneous push -> pop and push both succeed, overflow stays 0; in_ch=CHANNELS (non-power-of-2 config) -> no effect.
REQ-033 rst_n low mid-window with records buffered -> outputs zero immediately; post-release 2^WIN_LOG2 samples needed before first record.
